// File: rtl/mesi_isc_tb_ins_gen.sv
// Per-CPU NOP/WR/RD stimulus generator driving the tb_ins handshake of one CPU model.
// Optional ack watchdog: define MESI_ISC_TB_INS_GEN_ACK_TIMEOUT_EN.
module mesi_isc_tb_ins_gen #(
    parameter int          ADDR_WIDTH    = 32,
    parameter int          INS_WIDTH     = 4,
    parameter logic [31:0] SEED          = 32'hACE1_0001,
    parameter int          ADDR_SEL_BITS = 2,
    parameter int          ACK_TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [15:0]           ins_count_i,
    input  logic                  tb_ins_ack_i,
    output logic [INS_WIDTH-1:0]  tb_ins_o,
    output logic [ADDR_WIDTH-1:0] tb_ins_addr_o,
    output logic [15:0]           issued_cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [INS_WIDTH-1:0] INS_NOP = INS_WIDTH'(0);
    localparam logic [INS_WIDTH-1:0] INS_WR  = INS_WIDTH'(1);
    localparam logic [INS_WIDTH-1:0] INS_RD  = INS_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_ISSUE, S_ACKLOW, S_NOPW, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [31:0]             lfsr, lfsr_nxt, lfsr_adv;
    logic [INS_WIDTH-1:0]    ins, ins_nxt;
    logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
    logic [15:0]             issued, issued_nxt;
    logic [15:0]             count, count_nxt;
    logic [3:0]              nop_cnt, nop_nxt;

`ifdef MESI_ISC_TB_INS_GEN_ACK_TIMEOUT_EN
    localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
    logic [WD_W-1:0] wd, wd_nxt;
    logic            err, err_nxt;
`endif

    // Galois right-shift form; fields are always taken from the advanced value.
    assign lfsr_adv = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);

    always_comb begin
        state_nxt  = state;
        lfsr_nxt   = lfsr;
        ins_nxt    = ins;
        addr_nxt   = addr;
        issued_nxt = issued;
        count_nxt  = count;
        nop_nxt    = nop_cnt;
`ifdef MESI_ISC_TB_INS_GEN_ACK_TIMEOUT_EN
        wd_nxt     = wd;
        err_nxt    = err;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    issued_nxt = 16'd0;
                    if (ins_count_i != 16'd0) begin
                        count_nxt = ins_count_i;
                        state_nxt = S_GEN;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_GEN: begin
                lfsr_nxt = lfsr_adv;
                if (lfsr_adv[1:0] == 2'b00) begin
                    ins_nxt   = INS_NOP;
                    nop_nxt   = lfsr_adv[7:4];
                    state_nxt = S_NOPW;
                end else begin
                    ins_nxt   = lfsr_adv[1] ? INS_RD : INS_WR;
                    addr_nxt  = ADDR_WIDTH'(lfsr_adv[8 +: ADDR_SEL_BITS]);
                    state_nxt = S_ISSUE;
`ifdef MESI_ISC_TB_INS_GEN_ACK_TIMEOUT_EN
                    wd_nxt    = '0;
`endif
                end
            end
            S_ISSUE: begin
                if (tb_ins_ack_i) begin
                    ins_nxt    = INS_NOP;
                    issued_nxt = issued + 16'd1;
                    state_nxt  = S_ACKLOW;
                end
`ifdef MESI_ISC_TB_INS_GEN_ACK_TIMEOUT_EN
                else if (wd == WD_W'(ACK_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    ins_nxt   = INS_NOP;
                    state_nxt = S_DONE;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
`endif
            end
            S_ACKLOW: begin
                // A held ack must drop before the next instruction is generated.
                if (!tb_ins_ack_i)
                    state_nxt = (issued == count) ? S_DONE : S_GEN;
            end
            S_NOPW: begin
                if (nop_cnt == 4'd0) begin
                    issued_nxt = issued + 16'd1;
                    state_nxt  = (issued + 16'd1 == count) ? S_DONE : S_GEN;
                end else begin
                    nop_nxt = nop_cnt - 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            lfsr    <= SEED_EFF;
            ins     <= INS_NOP;
            addr    <= '0;
            issued  <= 16'd0;
            count   <= 16'd0;
            nop_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            lfsr    <= lfsr_nxt;
            ins     <= ins_nxt;
            addr    <= addr_nxt;
            issued  <= issued_nxt;
            count   <= count_nxt;
            nop_cnt <= nop_nxt;
        end
    end

`ifdef MESI_ISC_TB_INS_GEN_ACK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd  <= wd_nxt;
            err <= err_nxt;
        end
    end
    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

    assign tb_ins_o      = ins;
    assign tb_ins_addr_o = addr;
    assign issued_cnt_o  = issued;
    assign busy_o        = (state != S_IDLE) && (state != S_DONE);
    assign done_o        = (state == S_DONE);

endmodule

// File: tb/tb_mesi_isc_tb_ins_gen.sv
// Directed bench for mesi_isc_tb_ins_gen: LFSR-tracked instruction stream, stalls, resets, watchdog.
module tb_mesi_isc_tb_ins_gen;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cnt_in;
    logic        ack;
    logic [3:0]  tb_ins;
    logic [31:0] tb_addr;
    logic [15:0] issued;
    logic        busy, done, err;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] m_lfsr;

    mesi_isc_tb_ins_gen #(
        .ADDR_WIDTH(32), .INS_WIDTH(4), .SEED(32'h1),
        .ADDR_SEL_BITS(2), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .ins_count_i(cnt_in),
        .tb_ins_ack_i(ack), .tb_ins_o(tb_ins), .tb_ins_addr_o(tb_addr),
        .issued_cnt_o(issued), .busy_o(busy), .done_o(done), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; ack = 1'b0; cnt_in = 16'd0;
        m_lfsr = 32'h1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE/DONE; returns one negedge later.
    task automatic do_start(input logic [15:0] n);
        start = 1'b1; cnt_in = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge with the FSM in GEN; returns at a negedge in GEN or DONE.
    task automatic do_ins(input int idx);
        logic [31:0] op;
        logic [31:0] a;
        int          len;
        m_lfsr = lfsr_step(m_lfsr);
        op  = m_lfsr[1] ? 32'd2 : (m_lfsr[0] ? 32'd1 : 32'd0);
        a   = {30'd0, m_lfsr[9:8]};
        if (op == 32'd0) begin
            len = int'(m_lfsr[7:4]) + 1;
            repeat (len) @(negedge clk);
            chk("nop_early", 32'(issued), 32'(idx));
            @(negedge clk);
            chk("nop_done", 32'(issued), 32'(idx + 1));
            chk("nop_ins", 32'(tb_ins), 32'd0);
        end else begin
            @(negedge clk);
            chk("ins_op", 32'(tb_ins), op);
            chk("ins_addr", tb_addr, a);
            repeat (3) @(negedge clk);
            chk("ins_hold", 32'(tb_ins), op);
            ack = 1'b1;
            @(negedge clk);
            chk("ack_nop", 32'(tb_ins), 32'd0);
            chk("ack_cnt", 32'(issued), 32'(idx + 1));
            chk("ack_addr", tb_addr, a);
            ack = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; ack = 1'b0; cnt_in = 16'd0;
        m_lfsr = 32'h1;
        repeat (2) @(negedge clk);
        chk("rst_ins", 32'(tb_ins), 32'd0);
        chk("rst_addr", tb_addr, 32'd0);
        chk("rst_cnt", 32'(issued), 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // First run of 8 from SEED=1
        do_start(16'd8);
        chk("run1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) do_ins(i);
        chk("run1_cnt", 32'(issued), 32'd8);
        chk("run1_flags", {30'd0, busy, done}, 32'd1);

        // Back-to-back run continues the LFSR stream
        do_start(16'd5);
        chk("b2b_clear", 32'(issued), 32'd0);
        for (int i = 0; i < 5; i++) do_ins(i);
        chk("b2b_cnt", 32'(issued), 32'd5);
        chk("b2b_done", 32'(done), 32'd1);

        // Zero count from DONE
        do_start(16'd0);
        chk("zero_done", {30'd0, busy, done}, 32'd1);
        chk("zero_cnt", 32'(issued), 32'd0);
        chk("zero_ins", 32'(tb_ins), 32'd0);

        // Reset during ISSUE of instruction 3, then reproduce from the seed
        do_reset();
        do_start(16'd8);
        do_ins(0);
        do_ins(1);
        m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
        chk("mid_ins3", 32'(tb_ins), m_lfsr[1] ? 32'd2 : 32'(m_lfsr[0]));
        rst = 1'b0;
        #1;
        chk("mid_ins", 32'(tb_ins), 32'd0);
        chk("mid_addr", tb_addr, 32'd0);
        chk("mid_cnt", 32'(issued), 32'd0);
        chk("mid_flags", {29'd0, busy, done, err}, 32'd0);
        m_lfsr = 32'h1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_start(16'd4);
        for (int i = 0; i < 4; i++) do_ins(i);
        chk("rerun_cnt", 32'(issued), 32'd4);
        chk("rerun_done", 32'(done), 32'd1);

        // Zero count from IDLE
        do_reset();
        do_start(16'd0);
        chk("zidle_done", {30'd0, busy, done}, 32'd1);
        chk("zidle_ins", 32'(tb_ins), 32'd0);

        // Ack held high: one instruction, then stall in ACKLOW
        do_reset();
        ack = 1'b1;
        do_start(16'd4);
        m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
        chk("early_op", 32'(tb_ins), m_lfsr[1] ? 32'd2 : 32'(m_lfsr[0]));
        repeat (8) @(negedge clk);
        chk("early_cnt", 32'(issued), 32'd1);
        chk("early_ins", 32'(tb_ins), 32'd0);
        chk("early_busy", 32'(busy), 32'd1);
        ack = 1'b0;
        @(negedge clk);
        for (int i = 1; i < 4; i++) do_ins(i);
        chk("early_end", 32'(issued), 32'd4);
        chk("early_done", 32'(done), 32'd1);

        // Never acked instruction
        do_reset();
        do_start(16'd4);
        m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
        chk("wd_op", 32'(tb_ins), 32'd2);
`ifdef MESI_ISC_TB_INS_GEN_ACK_TIMEOUT_EN
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wd_cycles", 32'(n), 32'd16);
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_ins", 32'(tb_ins), 32'd0);
        chk("wd_done", 32'(done), 32'd1);
        do_start(16'd1);
        chk("wd_restart", {30'd0, busy, err}, 32'd3);
`else
        n = 0;
        repeat (40) begin
            @(negedge clk);
            n++;
        end
        chk("wd_hold", 32'(tb_ins), 32'd2);
        chk("wd_flags", {29'd0, busy, done, err}, 32'd4);
        chk("wd_cnt", 32'(issued), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
